// File: rtl/controle_busca_instrucao_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// ROM padding word and PC step.
package controle_busca_instrucao_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } estado_t;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/controle_busca_instrucao_pc_registrador.sv
// PC register: async reset, word-aligned redirect load and increment by
// PC_STEP that wraps naturally at 2^ADDR_W.
module pc_registrador
    import controle_busca_instrucao_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              incr,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'b11);

    // Redirect wins over increment; low address bits are forced to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= load_pc & ALIGN_MASK;
        end else if (incr) begin
            pc <= pc + ADDR_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/controle_busca_instrucao.sv
// Instruction-fetch sequencer: walks the ROM, holds one fetched word in a
// valid/ready slot for decode, takes redirects and halts on the padding word.
module controle_busca_instrucao
    import controle_busca_instrucao_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    estado_t           estado;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              palavra_nula;
    logic              em_fetch;
    logic              pc_incr;
    logic              pc_load;

    assign slot_free    = !instr_valid || instr_ready;
    assign palavra_nula = (i_mem_data == DATA_W'(HALT_WORD));
    assign em_fetch     = (estado == FETCH);
    assign pc_load      = em_fetch && redirect_valid;
    assign pc_incr      = em_fetch && !redirect_valid && slot_free && !palavra_nula;
    assign i_mem_addr   = pc;

    pc_registrador #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .incr    (pc_incr),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    // FSM, output slot and handshake counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= IDLE;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            pc_out      <= '0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (instr_valid && instr_ready) begin
                instr_count <= instr_count + CNT_W'(1);
            end

            case (estado)
                IDLE: begin
                    if (start) begin
                        estado <= FETCH;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                    end else if (slot_free) begin
                        if (palavra_nula) begin
                            instr_valid <= 1'b0;
                            halted      <= 1'b1;
                            estado      <= HALT;
                        end else begin
                            instr_out   <= i_mem_data;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_busca_instrucao.sv
// Directed bench for controle_busca_instrucao with a scoreboard of expected
// {pc, instruction} handshakes checked by an independent monitor.
module tb_controle_busca_instrucao;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    logic [DATA_W-1:0] rom [16];
    logic [ADDR_W+DATA_W-1:0] sb [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign i_mem_data = rom[i_mem_addr[5:2]];

    controle_busca_instrucao #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RESET_PC(0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .i_mem_addr     (i_mem_addr),
        .i_mem_data     (i_mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    function automatic logic [DATA_W-1:0] word_of(int idx);
        return 32'h0000_0083 | (32'(idx) << 12);
    endfunction

    // zero_idx outside 0..15 means a fully non-zero ROM
    task automatic fill_rom(int zero_idx);
        for (int i = 0; i < 16; i++) begin
            rom[i] = (i == zero_idx) ? 32'h0 : word_of(i);
        end
    endtask

    task automatic push(int pc);
        sb.push_back({ADDR_W'(pc), word_of(pc / 4)});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Monitor: every completed handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got pc %0d instr %h expected no handshake",
                         pc_out, instr_out);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = sb.pop_front();
                if ({pc_out, instr_out} !== e) begin
                    n_bad++;
                    $display("FAIL sb_handshake: got pc %0d instr %h expected pc %0d instr %h",
                             pc_out, instr_out, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; instr_ready = 1'b0;
        fill_rom(3);
        #2;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_addr", 32'(i_mem_addr), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        reset = 1'b0;
        cyc();

        // Sequential fetch, halt on zero word at pc 12
        instr_ready = 1'b1;
        push(0); push(4); push(8);
        do_start();
        chk("seq_n1_valid", 32'(instr_valid), 32'd0);
        cyc(); chk("seq_n2_pc", 32'(pc_out), 32'd0);
        chk("seq_n2_valid", 32'(instr_valid), 32'd1);
        cyc(); chk("seq_n3_pc", 32'(pc_out), 32'd4);
        cyc(); chk("seq_n4_pc", 32'(pc_out), 32'd8);
        cyc(); chk("seq_halted", 32'(halted), 32'd1);
        chk("seq_valid_off", 32'(instr_valid), 32'd0);
        chk("seq_count", 32'(instr_count), 32'd3);
        chk("seq_addr", 32'(i_mem_addr), 32'd12);
        redirect_valid = 1'b1; redirect_pc = 6'd20; start = 1'b1;
        cyc(); cyc();
        redirect_valid = 1'b0; start = 1'b0;
        chk("halt_addr_frozen", 32'(i_mem_addr), 32'd12);
        chk("halt_sticky", 32'(halted), 32'd1);

        // Backpressure holds slot and PC
        do_reset();
        instr_ready = 1'b0;
        push(0); push(4); push(8);
        do_start();
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("bp_pc", 32'(pc_out), 32'd0);
            chk("bp_instr", instr_out, word_of(0));
            chk("bp_addr", 32'(i_mem_addr), 32'd4);
            cyc();
        end
        instr_ready = 1'b1;
        cyc(); chk("bp_resume_pc", 32'(pc_out), 32'd4);
        cyc(); cyc();
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_count", 32'(instr_count), 32'd3);

        // Redirect to 27 -> aligned 24 in the cycle pc 8 is accepted
        do_reset();
        fill_rom(9);
        push(0); push(4); push(8);
        do_start();
        cyc(); cyc(); cyc();
        chk("rd_pc8", 32'(pc_out), 32'd8);
        redirect_valid = 1'b1; redirect_pc = 6'd27;
        cyc();
        redirect_valid = 1'b0;
        chk("rd_flush", 32'(instr_valid), 32'd0);
        chk("rd_addr", 32'(i_mem_addr), 32'd24);
        chk("rd_count", 32'(instr_count), 32'd3);
        push(24); push(28); push(32);
        cyc(); chk("rd_target", 32'(pc_out), 32'd24);
        cyc(); cyc(); cyc();
        chk("rd_halted", 32'(halted), 32'd1);
        chk("rd_count_end", 32'(instr_count), 32'd6);

        // Redirect masks the zero word at pc 12
        do_reset();
        fill_rom(3);
        push(0); push(4); push(8);
        do_start();
        cyc(); cyc(); cyc();
        chk("mask_addr12", 32'(i_mem_addr), 32'd12);
        redirect_valid = 1'b1; redirect_pc = 6'd0;
        cyc();
        redirect_valid = 1'b0;
        chk("mask_no_halt", 32'(halted), 32'd0);
        chk("mask_addr0", 32'(i_mem_addr), 32'd0);
        push(0); push(4); push(8);
        cyc(); cyc(); cyc(); cyc();
        chk("mask_halted", 32'(halted), 32'd1);
        chk("mask_count", 32'(instr_count), 32'd6);

        // Wrap-around 60 -> 0, then reset mid-operation under backpressure
        do_reset();
        fill_rom(99);
        push(0);
        do_start();
        cyc();
        redirect_valid = 1'b1; redirect_pc = 6'd60;
        cyc();
        redirect_valid = 1'b0;
        chk("wrap_addr60", 32'(i_mem_addr), 32'd60);
        push(60);
        cyc(); chk("wrap_pc60", 32'(pc_out), 32'd60);
        cyc();
        instr_ready = 1'b0;
        chk("wrap_pc0", 32'(pc_out), 32'd0);
        chk("wrap_instr0", instr_out, word_of(0));
        chk("wrap_count", 32'(instr_count), 32'd2);
        chk("wrap_addr4", 32'(i_mem_addr), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_count", 32'(instr_count), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_addr", 32'(i_mem_addr), 32'd0);
        reset = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 6'd20; instr_ready = 1'b1;
        cyc(); cyc();
        redirect_valid = 1'b0;
        chk("idle_addr", 32'(i_mem_addr), 32'd0);
        chk("idle_valid", 32'(instr_valid), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
